// File: rtl/coherence_bus_arbiter.sv
// Two-cache arbiter for a shared memory port with write-invalidate coherence.
// One transaction in flight; round-robin between caches when both request.
module coherence_bus_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    input  logic [24:0] req_0,
    input  logic [24:0] req_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    output logic        mem_req_valid,
    output logic [24:0] mem_req,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [15:0] mem_resp,
    output logic        resp_valid_0,
    output logic        resp_valid_1,
    output logic [15:0] resp_data,
    output logic        inv_valid_0,
    output logic        inv_valid_1,
    output logic [15:0] inv_addr,
    input  logic        inv_ack_0,
    input  logic        inv_ack_1
);

    localparam int unsigned REQ_W  = 25;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CMD_B  = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_INVAL
    } state_t;

    state_t              r_state;
    logic                r_ptr;
    logic                r_owner;
    logic                r_req_ready_0;
    logic                r_req_ready_1;
    logic                r_mem_req_valid;
    logic [REQ_W-1:0]    r_mem_req;
    logic                r_resp_valid_0;
    logic                r_resp_valid_1;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_inv_valid_0;
    logic                r_inv_valid_1;
    logic [ADDR_W-1:0]   r_inv_addr;

    logic w_any_req;
    logic w_sel;
    logic w_other_ack;

    // Pointer only matters on a tie; a lone requester wins outright.
    assign w_any_req   = req_valid_0 | req_valid_1;
    assign w_sel       = (req_valid_0 & req_valid_1) ? r_ptr : req_valid_1;
    assign w_other_ack = r_owner ? inv_ack_0 : inv_ack_1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_ptr           <= 1'b0;
            r_owner         <= 1'b0;
            r_req_ready_0   <= 1'b0;
            r_req_ready_1   <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req       <= '0;
            r_resp_valid_0  <= 1'b0;
            r_resp_valid_1  <= 1'b0;
            r_resp_data     <= '0;
            r_inv_valid_0   <= 1'b0;
            r_inv_valid_1   <= 1'b0;
            r_inv_addr      <= '0;
        end else begin
            r_req_ready_0  <= 1'b0;
            r_req_ready_1  <= 1'b0;
            r_resp_valid_0 <= 1'b0;
            r_resp_valid_1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_mem_req     <= w_sel ? req_1 : req_0;
                        r_owner       <= w_sel;
                        r_ptr         <= ~w_sel;
                        r_req_ready_0 <= ~w_sel;
                        r_req_ready_1 <= w_sel;
                        r_state       <= ST_ISSUE;
                    end
                end
                // First ISSUE cycle only raises valid, so memory sees it one cycle after the grant.
                ST_ISSUE: begin
                    if (!r_mem_req_valid) begin
                        r_mem_req_valid <= 1'b1;
                    end else if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        if (r_mem_req[CMD_B]) begin
                            r_inv_addr    <= r_mem_req[ADDR_W-1:0];
                            r_inv_valid_0 <= r_owner;
                            r_inv_valid_1 <= ~r_owner;
                            r_state       <= ST_INVAL;
                        end else begin
                            r_resp_data    <= mem_resp;
                            r_resp_valid_0 <= ~r_owner;
                            r_resp_valid_1 <= r_owner;
                            r_state        <= ST_IDLE;
                        end
                    end
                end
                ST_INVAL: begin
                    if (w_other_ack) begin
                        r_inv_valid_0  <= 1'b0;
                        r_inv_valid_1  <= 1'b0;
                        r_resp_data    <= '0;
                        r_resp_valid_0 <= ~r_owner;
                        r_resp_valid_1 <= r_owner;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_0   = r_req_ready_0;
    assign req_ready_1   = r_req_ready_1;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req       = r_mem_req;
    assign resp_valid_0  = r_resp_valid_0;
    assign resp_valid_1  = r_resp_valid_1;
    assign resp_data     = r_resp_data;
    assign inv_valid_0   = r_inv_valid_0;
    assign inv_valid_1   = r_inv_valid_1;
    assign inv_addr      = r_inv_addr;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a transaction-level model.
module tb_coherence_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic [24:0] req_0 = '0, req_1 = '0;
    logic        req_ready_0, req_ready_1;
    logic        mem_req_valid;
    logic [24:0] mem_req;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [15:0] mem_resp = '0;
    logic        resp_valid_0, resp_valid_1;
    logic [15:0] resp_data;
    logic        inv_valid_0, inv_valid_1;
    logic [15:0] inv_addr;
    logic        inv_ack_0 = 1'b0, inv_ack_1 = 1'b0;

    always #5 clock = ~clock;

    coherence_bus_arbiter dut (
        .clock(clock), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_0(req_0), .req_1(req_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .mem_req_valid(mem_req_valid), .mem_req(mem_req),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp(mem_resp),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_data(resp_data),
        .inv_valid_0(inv_valid_0), .inv_valid_1(inv_valid_1),
        .inv_addr(inv_addr),
        .inv_ack_0(inv_ack_0), .inv_ack_1(inv_ack_1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: where the single transaction is in its life, who owns it, whose turn is next.
    localparam int FREE = 0, GRANTED = 1, AT_MEM = 2, AWAIT_DATA = 3, INVALIDATING = 4;
    int          txn = FREE;
    int          turn = 0;
    int          owner = 0;
    logic [24:0] txn_req = '0;
    logic [1:0]  e_rr = '0, e_rv = '0, e_inv = '0;
    logic        e_mvalid = 1'b0;
    logic [24:0] e_mreq = '0;
    logic [15:0] e_rdata = '0, e_iaddr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int g;
        e_rr = '0;
        e_rv = '0;
        if (reset) begin
            txn = FREE; turn = 0; e_mvalid = 1'b0; e_mreq = '0;
            e_rdata = '0; e_inv = '0; e_iaddr = '0;
        end else if (txn == FREE) begin
            g = -1;
            if (req_valid_0 && req_valid_1) g = turn;
            else if (req_valid_0) g = 0;
            else if (req_valid_1) g = 1;
            if (g >= 0) begin
                owner = g;
                txn_req = (g == 1) ? req_1 : req_0;
                e_mreq = txn_req;
                turn = 1 - g;
                e_rr[g] = 1'b1;
                txn = GRANTED;
            end
        end else if (txn == GRANTED) begin
            e_mvalid = 1'b1;
            txn = AT_MEM;
        end else if (txn == AT_MEM) begin
            if (mem_req_ready) begin
                e_mvalid = 1'b0;
                txn = AWAIT_DATA;
            end
        end else if (txn == AWAIT_DATA) begin
            if (mem_resp_valid) begin
                if (txn_req[24]) begin
                    e_inv[1-owner] = 1'b1;
                    e_iaddr = txn_req[15:0];
                    txn = INVALIDATING;
                end else begin
                    e_rdata = mem_resp;
                    e_rv[owner] = 1'b1;
                    txn = FREE;
                end
            end
        end else begin
            if ((owner == 0 && inv_ack_1) || (owner == 1 && inv_ack_0)) begin
                e_inv = '0;
                e_rdata = '0;
                e_rv[owner] = 1'b1;
                txn = FREE;
            end
        end
    endtask

    task automatic compare_all();
        chk("req_ready_0", 32'(req_ready_0), 32'(e_rr[0]));
        chk("req_ready_1", 32'(req_ready_1), 32'(e_rr[1]));
        chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mvalid));
        chk("resp_valid_0", 32'(resp_valid_0), 32'(e_rv[0]));
        chk("resp_valid_1", 32'(resp_valid_1), 32'(e_rv[1]));
        chk("inv_valid_0", 32'(inv_valid_0), 32'(e_inv[0]));
        chk("inv_valid_1", 32'(inv_valid_1), 32'(e_inv[1]));
        if (e_mvalid) chk("mem_req", 32'(mem_req), 32'(e_mreq));
        if (e_rv != 2'b00) chk("resp_data", 32'(resp_data), 32'(e_rdata));
        if (e_inv != 2'b00) chk("inv_addr", 32'(inv_addr), 32'(e_iaddr));
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic quiet_reset();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        inv_ack_0 = 1'b0; inv_ack_1 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rr"}, 32'({req_ready_1, req_ready_0}), 32'd0);
        chk({tag, "_mvalid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_mreq"}, 32'(mem_req), 32'd0);
        chk({tag, "_rv"}, 32'({resp_valid_1, resp_valid_0}), 32'd0);
        chk({tag, "_rdata"}, 32'(resp_data), 32'd0);
        chk({tag, "_inv"}, 32'({inv_valid_1, inv_valid_0}), 32'd0);
        chk({tag, "_iaddr"}, 32'(inv_addr), 32'd0);
    endtask

    initial begin
        int grants[$];
        int exp_pat[4];
        exp_pat = '{0, 1, 0, 1};

        step();
        quiet_reset();
        chk_all_zero("reset");

        // Single read from cache 0
        req_valid_0 = 1'b1; req_0 = 25'h0001234;
        step();
        chk("s1_ready0", 32'(req_ready_0), 32'd1);
        req_valid_0 = 1'b0; mem_req_ready = 1'b1;
        step();
        chk("s1_mvalid", 32'(mem_req_valid), 32'd1);
        chk("s1_mreq", 32'(mem_req), 32'h0001234);
        step();
        mem_req_ready = 1'b0;
        step();
        mem_resp_valid = 1'b1; mem_resp = 16'hBEEF;
        step();
        chk("s1_rv0", 32'(resp_valid_0), 32'd1);
        chk("s1_rdata", 32'(resp_data), 32'hBEEF);
        chk("s1_noinv", 32'({inv_valid_1, inv_valid_0}), 32'd0);
        mem_resp_valid = 1'b0;
        step();

        // Write from cache 1 with delayed invalidate ack from cache 0
        req_valid_1 = 1'b1; req_1 = 25'h1A54C02;
        step();
        chk("s2_ready1", 32'(req_ready_1), 32'd1);
        req_valid_1 = 1'b0; mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp = 16'h1111;
        step();
        mem_resp_valid = 1'b0; inv_ack_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("s2_inv0", 32'(inv_valid_0), 32'd1);
            chk("s2_inv1", 32'(inv_valid_1), 32'd0);
            chk("s2_iaddr", 32'(inv_addr), 32'h4C02);
            chk("s2_early_rv1", 32'(resp_valid_1), 32'd0);
            if (i == 2) inv_ack_0 = 1'b1;
            step();
        end
        chk("s2_rv1", 32'(resp_valid_1), 32'd1);
        chk("s2_rdata", 32'(resp_data), 32'd0);
        inv_ack_0 = 1'b0; inv_ack_1 = 1'b0;
        step();

        // Fairness: both caches keep a read pending
        quiet_reset();
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp = 16'h0;
        req_valid_0 = 1'b1; req_0 = 25'h0000010;
        req_valid_1 = 1'b1; req_1 = 25'h0000020;
        for (int c = 0; c < 40; c++) begin
            step();
            if (req_ready_0) grants.push_back(0);
            if (req_ready_1) grants.push_back(1);
            if (e_rr[0]) req_0 = {1'b0, 24'($urandom)};
            if (e_rr[1]) req_1 = {1'b0, 24'($urandom)};
        end
        chk("s3_grant_count", 32'(grants.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) chk("s3_order", 32'(grants[i]), 32'(exp_pat[i]));

        // Memory backpressure with stray responses during issue
        quiet_reset();
        req_valid_0 = 1'b1; req_0 = 25'h05AC3D2;
        step();
        req_valid_0 = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("s4_mvalid", 32'(mem_req_valid), 32'd1);
            chk("s4_mreq", 32'(mem_req), 32'h05AC3D2);
            mem_resp_valid = 1'b1; mem_resp = 16'hDEAD;
            step();
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        chk("s4_mvalid_hold", 32'(mem_req_valid), 32'd1);
        step();
        mem_req_ready = 1'b0;
        chk("s4_accepted", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_resp = 16'h0042;
        step();
        chk("s4_rdata", 32'(resp_data), 32'h0042);
        mem_resp_valid = 1'b0;

        // Reset in the middle of an invalidate
        quiet_reset();
        req_valid_0 = 1'b1; req_0 = 25'h1000777;
        step();
        req_valid_0 = 1'b0; mem_req_ready = 1'b1;
        step();
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        chk("s5_inv1", 32'(inv_valid_1), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("s5");
        req_valid_0 = 1'b1; req_0 = 25'h0000100;
        req_valid_1 = 1'b1; req_1 = 25'h0000200;
        step();
        chk("s5_ptr0", 32'({req_ready_1, req_ready_0}), 32'd1);

        // Randomized traffic
        quiet_reset();
        for (int c = 0; c < 4000; c++) begin
            if (e_rr[0]) req_valid_0 = 1'b0;
            else if (!req_valid_0 && $urandom_range(0, 2) == 0) begin
                req_valid_0 = 1'b1; req_0 = 25'($urandom);
            end
            if (e_rr[1]) req_valid_1 = 1'b0;
            else if (!req_valid_1 && $urandom_range(0, 2) == 0) begin
                req_valid_1 = 1'b1; req_1 = 25'($urandom);
            end
            mem_req_ready  = ($urandom_range(0, 2) == 0);
            mem_resp_valid = ($urandom_range(0, 3) == 0);
            mem_resp       = 16'($urandom);
            inv_ack_0      = ($urandom_range(0, 2) == 0);
            inv_ack_1      = ($urandom_range(0, 2) == 0);
            reset          = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
